// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/execute sequencer with a single-level interrupt.
// Owns the program counter, saved return address and in-service flag.
module pc_seq_ctrl #(
  parameter logic [7:0] RESET_VEC = 8'h00,
  parameter logic [7:0] IRQ_VEC   = 8'hF0
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       START,
  input  logic       MEM_ACK,
  input  logic       BR_TAKEN,
  input  logic [7:0] BR_TARGET,
  input  logic       RETI,
  input  logic       IRQ,
  input  logic       HALT_REQ,
  output logic [7:0] PC,
  output logic       MEM_REQ,
  output logic       EXEC_EN,
  output logic       IRQ_ACK,
  output logic [7:0] EPC,
  output logic       HALTED
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_epc;
  logic       r_is;
  logic       r_irq_ack;

  state_t     w_state_nx;
  logic [7:0] w_pc_nx;
  logic [7:0] w_epc_nx;
  logic       w_is_nx;
  logic       w_ack_nx;
  logic [7:0] w_pc_inc;

  // Sequential address; 8-bit add drops the carry so FE wraps to 00.
  assign w_pc_inc = r_pc + 8'd2;

  // Next-state and datapath selection; EXEC resolves one winner.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_epc_nx   = r_epc;
    w_is_nx    = r_is;
    w_ack_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (START) w_state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (MEM_ACK) w_state_nx = S_EXEC;
      end
      S_EXEC: begin
        w_state_nx = S_FETCH;
        if (HALT_REQ) begin
          w_state_nx = S_HALTED;
          w_pc_nx    = w_pc_inc;
        end else if (IRQ && !r_is) begin
          w_epc_nx = w_pc_inc;
          w_pc_nx  = IRQ_VEC;
          w_is_nx  = 1'b1;
          w_ack_nx = 1'b1;
        end else if (RETI) begin
          w_pc_nx = r_epc;
          w_is_nx = 1'b0;
        end else if (BR_TAKEN) begin
          w_pc_nx = {BR_TARGET[7:1], 1'b0};
        end else begin
          w_pc_nx = w_pc_inc;
        end
      end
      S_HALTED: begin
        if (START) w_state_nx = S_FETCH;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset wins over all inputs.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_VEC;
      r_epc     <= 8'h00;
      r_is      <= 1'b0;
      r_irq_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_epc     <= w_epc_nx;
      r_is      <= w_is_nx;
      r_irq_ack <= w_ack_nx;
    end
  end

  assign PC      = r_pc;
  assign EPC     = r_epc;
  assign IRQ_ACK = r_irq_ack;
  assign MEM_REQ = (r_state == S_FETCH);
  assign EXEC_EN = (r_state == S_EXEC);
  assign HALTED  = (r_state == S_HALTED);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed vectors for the fetch/execute sequencer.
// Expected values are hand-computed constants.
module tb_pc_seq_ctrl;

  logic       CLK;
  logic       RESET_L;
  logic       START;
  logic       MEM_ACK;
  logic       BR_TAKEN;
  logic [7:0] BR_TARGET;
  logic       RETI;
  logic       IRQ;
  logic       HALT_REQ;
  logic [7:0] PC;
  logic       MEM_REQ;
  logic       EXEC_EN;
  logic       IRQ_ACK;
  logic [7:0] EPC;
  logic       HALTED;

  int n_cmp;
  int n_err;

  pc_seq_ctrl dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .START     (START),
    .MEM_ACK   (MEM_ACK),
    .BR_TAKEN  (BR_TAKEN),
    .BR_TARGET (BR_TARGET),
    .RETI      (RETI),
    .IRQ       (IRQ),
    .HALT_REQ  (HALT_REQ),
    .PC        (PC),
    .MEM_REQ   (MEM_REQ),
    .EXEC_EN   (EXEC_EN),
    .IRQ_ACK   (IRQ_ACK),
    .EPC       (EPC),
    .HALTED    (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // From FETCH: wait `waits` cycles without ack, then ack into EXEC.
  task automatic do_fetch(input int waits, input logic [7:0] pc_exp);
    for (int i = 0; i < waits; i++) begin
      MEM_ACK = 1'b0;
      step();
      chk("fetch_wait_req", int'(MEM_REQ), 1);
      chk("fetch_wait_pc", int'(PC), int'(pc_exp));
    end
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    chk("exec_en", int'(EXEC_EN), 1);
    chk("exec_req", int'(MEM_REQ), 0);
    chk("exec_pc", int'(PC), int'(pc_exp));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    RESET_L   = 1'b0;
    START     = 1'b0;
    MEM_ACK   = 1'b0;
    BR_TAKEN  = 1'b0;
    BR_TARGET = 8'h00;
    RETI      = 1'b0;
    IRQ       = 1'b0;
    HALT_REQ  = 1'b0;
    step();
    step();
    chk("rst_pc", int'(PC), 8'h00);
    chk("rst_epc", int'(EPC), 8'h00);
    chk("rst_req", int'(MEM_REQ), 0);
    chk("rst_exec", int'(EXEC_EN), 0);
    chk("rst_halt", int'(HALTED), 0);
    chk("rst_ack", int'(IRQ_ACK), 0);

    RESET_L = 1'b1;
    START   = 1'b1;
    step();
    START = 1'b0;
    chk("start_req", int'(MEM_REQ), 1);
    do_fetch(2, 8'h00);
    step();
    chk("seq0_pc", int'(PC), 8'h02);
    chk("seq0_exec_off", int'(EXEC_EN), 0);
    do_fetch(2, 8'h02);
    step();
    chk("seq1_pc", int'(PC), 8'h04);
    chk("seq1_exec_off", int'(EXEC_EN), 0);

    do_fetch(2, 8'h04);
    BR_TAKEN  = 1'b1;
    BR_TARGET = 8'hFE;
    step();
    BR_TAKEN = 1'b0;
    chk("br_fe", int'(PC), 8'hFE);
    do_fetch(0, 8'hFE);
    step();
    chk("wrap_pc", int'(PC), 8'h00);

    do_fetch(0, 8'h00);
    BR_TAKEN  = 1'b1;
    BR_TARGET = 8'h35;
    step();
    chk("br_35", int'(PC), 8'h34);
    do_fetch(0, 8'h34);
    BR_TARGET = 8'h10;
    step();
    BR_TAKEN = 1'b0;
    chk("br_10", int'(PC), 8'h10);

    do_fetch(0, 8'h10);
    IRQ       = 1'b1;
    BR_TAKEN  = 1'b1;
    BR_TARGET = 8'h44;
    step();
    BR_TAKEN = 1'b0;
    chk("irq_pc", int'(PC), 8'hF0);
    chk("irq_epc", int'(EPC), 8'h12);
    chk("irq_ack", int'(IRQ_ACK), 1);
    do_fetch(0, 8'hF0);
    chk("irq_ack_drop", int'(IRQ_ACK), 0);
    step();
    chk("nest_pc", int'(PC), 8'hF2);
    chk("nest_ack", int'(IRQ_ACK), 0);
    chk("nest_epc", int'(EPC), 8'h12);
    do_fetch(0, 8'hF2);
    RETI = 1'b1;
    step();
    RETI = 1'b0;
    chk("reti_pc", int'(PC), 8'h12);
    chk("reti_ack", int'(IRQ_ACK), 0);
    do_fetch(0, 8'h12);
    step();
    IRQ = 1'b0;
    chk("irq2_pc", int'(PC), 8'hF0);
    chk("irq2_epc", int'(EPC), 8'h14);
    chk("irq2_ack", int'(IRQ_ACK), 1);
    do_fetch(0, 8'hF0);
    RETI = 1'b1;
    step();
    RETI = 1'b0;
    chk("reti2_pc", int'(PC), 8'h14);

    do_fetch(0, 8'h14);
    BR_TAKEN  = 1'b1;
    BR_TARGET = 8'h20;
    step();
    BR_TAKEN = 1'b0;
    do_fetch(0, 8'h20);
    HALT_REQ = 1'b1;
    IRQ      = 1'b1;
    step();
    HALT_REQ = 1'b0;
    IRQ      = 1'b0;
    chk("halt_flag", int'(HALTED), 1);
    chk("halt_pc", int'(PC), 8'h22);
    chk("halt_ack", int'(IRQ_ACK), 0);
    chk("halt_epc", int'(EPC), 8'h14);
    chk("halt_req", int'(MEM_REQ), 0);

    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    chk("hack_halt", int'(HALTED), 1);
    chk("hack_pc", int'(PC), 8'h22);
    chk("hack_exec", int'(EXEC_EN), 0);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("resume_req", int'(MEM_REQ), 1);
    chk("resume_halt", int'(HALTED), 0);
    chk("resume_pc", int'(PC), 8'h22);
    do_fetch(1, 8'h22);
    step();
    chk("resume_seq", int'(PC), 8'h24);

    MEM_ACK = 1'b1;
    RESET_L = 1'b0;
    step();
    chk("frst_req", int'(MEM_REQ), 0);
    chk("frst_exec", int'(EXEC_EN), 0);
    chk("frst_pc", int'(PC), 8'h00);
    chk("frst_epc", int'(EPC), 8'h00);
    RESET_L = 1'b1;
    step();
    MEM_ACK = 1'b0;
    chk("iack_req", int'(MEM_REQ), 0);
    chk("iack_exec", int'(EXEC_EN), 0);
    chk("iack_pc", int'(PC), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 8'h00, meaning the PC value loaded by reset.
REQ-002 SHALL have parameter IRQ_VEC, default 8'hF0, meaning the PC value loaded on interrupt entry.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_L  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port START  input  1  level; leaves IDLE or HALTED and begins fetching.
REQ-006 SHALL have port MEM_ACK  input  1  instruction memory has returned the word at PC.
REQ-007 SHALL have port BR_TAKEN  input  1  branch taken; sampled only in EXEC.
REQ-008 SHALL have port BR_TARGET  input  8  branch destination; sampled only in EXEC.
REQ-009 SHALL have port RETI  input  1  return from interrupt; sampled only in EXEC.
REQ-010 SHALL have port IRQ  input  1  interrupt request, level-sensitive.
REQ-011 SHALL have port HALT_REQ  input  1  halt request; sampled only in EXEC.
REQ-012 SHALL have port PC  output  8  current program counter (registered).
REQ-013 SHALL have port MEM_REQ  output  1  fetch request; high in FETCH.
REQ-014 SHALL have port EXEC_EN  output  1  one-cycle execute strobe; high in EXEC.
REQ-015 SHALL have port IRQ_ACK  output  1  one-cycle pulse on interrupt acceptance.
REQ-016 SHALL have port EPC  output  8  saved return address.
REQ-017 SHALL have port HALTED  output  1  high in HALTED.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, EXEC, HALTED, with MEM_REQ, EXEC_EN and HALTED decoded from state only (Moore).
REQ-019 SHALL, in IDLE, hold PC and go to FETCH on the edge where START=1.
REQ-020 SHALL, in FETCH, hold MEM_REQ=1 and PC stable for any number of cycles until MEM_ACK=1, then go to EXEC on that edge.
REQ-021 SHALL, in EXEC (exactly one cycle), update PC by priority HALT_REQ > accepted IRQ > RETI > BR_TAKEN > sequential, then go to FETCH (or HALTED for HALT_REQ).
REQ-022 SHALL, on HALT_REQ in EXEC, load PC <= PC+2 and enter HALTED.
REQ-023 SHALL accept IRQ in EXEC only when in-service flag IS=0: EPC <= PC+2, PC <= IRQ_VEC, IS <= 1, IRQ_ACK=1 for the following cycle only.
REQ-024 SHALL ignore IRQ while IS=1; a pending IRQ level is re-evaluated in each EXEC cycle.
REQ-025 SHALL, on RETI in EXEC without accepted IRQ, load PC <= EPC and clear IS; RETI with IS=0 also loads EPC.
REQ-026 SHALL, on BR_TAKEN, load PC <= {BR_TARGET[7:1],1'b0} (bit 0 forced to zero).
REQ-027 SHALL otherwise load PC <= PC+2, computed modulo 256 (8'hFE wraps to 8'h00, no carry out).
REQ-028 SHALL compute EPC as PC+2 modulo 256 (IRQ at PC=8'hFE saves 8'h00).
REQ-029 SHALL, in HALTED, hold PC and EPC and resume FETCH at the held PC on the edge where START=1.
REQ-030 SHALL ignore MEM_ACK outside FETCH and ignore START in FETCH and EXEC.

Reset
REQ-031 SHALL, on any edge with RESET_L=0 and in any state, set state=IDLE, PC=RESET_VEC, EPC=8'h00, IS=0, IRQ_ACK=0, abandoning any fetch in progress.
REQ-032 SHALL give reset priority over START, MEM_ACK, IRQ and all EXEC inputs on the same edge.
REQ-033 SHALL leave outputs undefined only before the first reset edge; after it MEM_REQ=EXEC_EN=HALTED=0.

Verification
REQ-034 Bench SHALL cover: reset, START=1, MEM_ACK each 3rd FETCH cycle, no branches -> PC 00,02,04 with EXEC_EN one cycle per instruction.
REQ-035 Bench SHALL cover: PC=8'hFE sequential EXEC -> PC=8'h00; BR_TAKEN with BR_TARGET=8'h35 -> PC=8'h34.
REQ-036 Bench SHALL cover: IRQ=1 with BR_TAKEN=1 in EXEC at PC=8'h10 -> PC=8'hF0, EPC=8'h12, IRQ_ACK one pulse; IRQ held high -> no re-entry; later RETI -> PC=8'h12, next IRQ accepted.
REQ-037 Bench SHALL cover: HALT_REQ and IRQ together at PC=8'h20 -> HALTED=1, PC=8'h22, no IRQ_ACK; START -> FETCH at 8'h22.
REQ-038 Bench SHALL cover: RESET_L=0 during FETCH with MEM_ACK=1 on the same edge -> state IDLE, PC=RESET_VEC, MEM_REQ=0, no EXEC_EN.
REQ-039 Bench SHALL cover: MEM_ACK pulses in IDLE and HALTED -> no state or PC change.
